// File: rtl/i2s_sample_scheduler.sv
// i2s_sample_scheduler: buffers left/right samples in per-channel FIFOs and
// presents the next channel's word to the I2S serializer on each DONE rise.
// Optional feature: define SCHED_UNDERRUN_CNT_EN to add the saturating
// underrun_count output.
module i2s_sample_scheduler #(
   parameter int unsigned DIN_W         = 16,
   parameter int unsigned DEPTH         = 4,
   parameter int unsigned PRIME_LVL     = 2,
   parameter int unsigned UNDERRUN_HOLD = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [DIN_W-1:0] l_data,
   input  logic             l_valid,
   output logic             l_ready,
   input  logic [DIN_W-1:0] r_data,
   input  logic             r_valid,
   output logic             r_ready,
   input  logic             done_in,
   output logic [DIN_W-1:0] data_out,
   output logic             chan,
   output logic             underrun,
   output logic [1:0]       state
`ifdef SCHED_UNDERRUN_CNT_EN
   ,
   output logic [15:0]      underrun_count
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      PRIME = 2'b01,
      RUN   = 2'b10
   } state_t;

   state_t           state_q, state_d;
   logic [DIN_W-1:0] data_d;
   logic             chan_d;
   logic             underrun_d;
   logic             pop_l, pop_r;
   logic [DIN_W-1:0] hold_l, hold_r, hold_l_d, hold_r_d;
   logic [DIN_W-1:0] fill_l, fill_r;

   logic [DIN_W-1:0] l_mem [DEPTH];
   logic [DIN_W-1:0] r_mem [DEPTH];
   logic [PW-1:0]    l_wr, l_rd, r_wr, r_rd;
   logic [PW-1:0]    l_lvl, r_lvl;
   logic             l_full, l_empty, r_full, r_empty;
   logic             l_push, r_push;
   logic             prime_ok;

   logic             s1, s2, s3;
   logic             done_pulse;

   // FIFO status from the extended-pointer scheme
   assign l_full   = (l_wr[PW-1] != l_rd[PW-1]) && (l_wr[AW-1:0] == l_rd[AW-1:0]);
   assign r_full   = (r_wr[PW-1] != r_rd[PW-1]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign l_empty  = (l_wr == l_rd);
   assign r_empty  = (r_wr == r_rd);
   assign l_lvl    = l_wr - l_rd;
   assign r_lvl    = r_wr - r_rd;
   assign l_ready  = ~l_full;
   assign r_ready  = ~r_full;
   assign l_push   = l_valid & ~l_full;
   assign r_push   = r_valid & ~r_full;
   assign prime_ok = (l_lvl >= PW'(PRIME_LVL)) && (r_lvl >= PW'(PRIME_LVL));

   assign fill_l     = (UNDERRUN_HOLD != 0) ? hold_l : '0;
   assign fill_r     = (UNDERRUN_HOLD != 0) ? hold_r : '0;
   assign done_pulse = s2 & ~s3;
   assign state      = state_q;

   // FIFO storage; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (l_push) l_mem[l_wr[AW-1:0]] <= l_data;
      if (r_push) r_mem[r_wr[AW-1:0]] <= r_data;
   end

   // FIFO pointers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         l_wr <= '0;
         l_rd <= '0;
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (l_push) l_wr <= l_wr + PW'(1);
         if (pop_l)  l_rd <= l_rd + PW'(1);
         if (r_push) r_wr <= r_wr + PW'(1);
         if (pop_r)  r_rd <= r_rd + PW'(1);
      end
   end

   // DONE synchronizer plus edge-detect flop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= done_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         data_out <= '0;
         chan     <= 1'b0;
         underrun <= 1'b0;
         hold_l   <= '0;
         hold_r   <= '0;
      end else begin
         state_q  <= state_d;
         data_out <= data_d;
         chan     <= chan_d;
         underrun <= underrun_d;
         hold_l   <= hold_l_d;
         hold_r   <= hold_r_d;
      end
   end

   // Next-state, pop requests and next output values
   always_comb begin
      state_d    = state_q;
      data_d     = data_out;
      chan_d     = chan;
      underrun_d = 1'b0;
      pop_l      = 1'b0;
      pop_r      = 1'b0;
      hold_l_d   = hold_l;
      hold_r_d   = hold_r;
      case (state_q)
         IDLE: begin
            data_d = '0;
            chan_d = 1'b0;
            if (enable) state_d = PRIME;
         end
         PRIME: begin
            if (!enable) begin
               state_d = IDLE;
               data_d  = '0;
               chan_d  = 1'b0;
            end else if (prime_ok) begin
               pop_l    = 1'b1;
               data_d   = l_mem[l_rd[AW-1:0]];
               hold_l_d = l_mem[l_rd[AW-1:0]];
               chan_d   = 1'b0;
               state_d  = RUN;
            end
         end
         RUN: begin
            if (!enable) begin
               state_d = IDLE;
               data_d  = '0;
               chan_d  = 1'b0;
            end else if (done_pulse) begin
               chan_d = ~chan;
               if (chan) begin
                  if (!l_empty) begin
                     pop_l    = 1'b1;
                     data_d   = l_mem[l_rd[AW-1:0]];
                     hold_l_d = l_mem[l_rd[AW-1:0]];
                  end else begin
                     data_d     = fill_l;
                     underrun_d = 1'b1;
                  end
               end else begin
                  if (!r_empty) begin
                     pop_r    = 1'b1;
                     data_d   = r_mem[r_rd[AW-1:0]];
                     hold_r_d = r_mem[r_rd[AW-1:0]];
                  end else begin
                     data_d     = fill_r;
                     underrun_d = 1'b1;
                  end
               end
            end
         end
         default: begin
            state_d = IDLE;
            data_d  = '0;
            chan_d  = 1'b0;
         end
      endcase
   end

`ifdef SCHED_UNDERRUN_CNT_EN
   // Saturating underrun counter, restarted each time the scheduler is enabled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         underrun_count <= '0;
      end else if ((state_q == IDLE) && (state_d == PRIME)) begin
         underrun_count <= '0;
      end else if (underrun_d && (underrun_count != 16'hFFFF)) begin
         underrun_count <= underrun_count + 16'd1;
      end
   end
`else
   // Counter absent in this build
`endif

endmodule

// File: tb/tb_i2s_sample_scheduler.sv
// Testbench for i2s_sample_scheduler: two instances (PRIME_LVL=2/zero fill and
// PRIME_LVL=1/hold fill) checked against a queue-based transaction model.
module tb_i2s_sample_scheduler;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        done_in = 1'b0;
   logic [1:0]  enable = 2'b00;
   logic [1:0]  l_valid = 2'b00, r_valid = 2'b00;
   logic [15:0] l_data0 = '0, l_data1 = '0, r_data0 = '0, r_data1 = '0;
   logic [1:0]  l_ready, r_ready, chan, urun;
   logic [15:0] data_o0, data_o1;
   logic [1:0]  st0, st1;
`ifdef SCHED_UNDERRUN_CNT_EN
   logic [15:0] cnt0, cnt1;
`endif

   int n_checks = 0;
   int n_err = 0;
   int seen [2] = '{0, 0};

   // model: per-dut state code, output word, channel, per-channel queues and hold
   int          m_state [2] = '{0, 0};
   logic [15:0] m_data  [2] = '{16'h0, 16'h0};
   logic        m_chan  [2] = '{1'b0, 1'b0};
   logic [15:0] m_hold  [4] = '{16'h0, 16'h0, 16'h0, 16'h0};
   int          m_urun  [2] = '{0, 0};
   int          m_cnt   [2] = '{0, 0};
   logic [15:0] mq [4][$];

   i2s_sample_scheduler #(.DIN_W(16), .DEPTH(4), .PRIME_LVL(2), .UNDERRUN_HOLD(0)) dut0 (
      .clk(clk), .rst(rst), .enable(enable[0]),
      .l_data(l_data0), .l_valid(l_valid[0]), .l_ready(l_ready[0]),
      .r_data(r_data0), .r_valid(r_valid[0]), .r_ready(r_ready[0]),
      .done_in(done_in), .data_out(data_o0), .chan(chan[0]),
      .underrun(urun[0]), .state(st0)
`ifdef SCHED_UNDERRUN_CNT_EN
      , .underrun_count(cnt0)
`endif
   );

   i2s_sample_scheduler #(.DIN_W(16), .DEPTH(4), .PRIME_LVL(1), .UNDERRUN_HOLD(1)) dut1 (
      .clk(clk), .rst(rst), .enable(enable[1]),
      .l_data(l_data1), .l_valid(l_valid[1]), .l_ready(l_ready[1]),
      .r_data(r_data1), .r_valid(r_valid[1]), .r_ready(r_ready[1]),
      .done_in(done_in), .data_out(data_o1), .chan(chan[1]),
      .underrun(urun[1]), .state(st1)
`ifdef SCHED_UNDERRUN_CNT_EN
      , .underrun_count(cnt1)
`endif
   );

   always #5 clk = ~clk;

   // count underrun pulses seen on each instance
   always @(negedge clk) begin
      if (urun[0]) seen[0] = seen[0] + 1;
      if (urun[1]) seen[1] = seen[1] + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int plvl(input int d);
      return (d == 0) ? 2 : 1;
   endfunction

   task automatic check_all();
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("data%0d", d), (d == 0) ? data_o0 : data_o1, m_data[d]);
         chk($sformatf("chan%0d", d), chan[d], m_chan[d]);
         chk($sformatf("state%0d", d), (d == 0) ? st0 : st1, m_state[d]);
         chk($sformatf("urun_pulses%0d", d), seen[d], m_urun[d]);
         chk($sformatf("l_ready%0d", d), l_ready[d], mq[d*2].size() < DEPTH);
         chk($sformatf("r_ready%0d", d), r_ready[d], mq[d*2+1].size() < DEPTH);
`ifdef SCHED_UNDERRUN_CNT_EN
         chk($sformatf("count%0d", d), (d == 0) ? cnt0 : cnt1, m_cnt[d]);
`endif
      end
   endtask

   // serializer word boundary: every running instance moves to the other channel
   function automatic void model_done();
      int idx;
      for (int d = 0; d < 2; d++) begin
         if (m_state[d] == 2) begin
            m_chan[d] = ~m_chan[d];
            idx = d * 2 + int'(m_chan[d]);
            if (mq[idx].size() > 0) begin
               m_data[d] = mq[idx].pop_front();
               m_hold[idx] = m_data[d];
            end else begin
               m_data[d] = (d == 1) ? m_hold[idx] : 16'h0;
               m_urun[d]++;
               m_cnt[d]++;
            end
         end
      end
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 4; i++) begin
         mq[i].delete();
         m_hold[i] = 16'h0;
      end
      for (int d = 0; d < 2; d++) begin
         m_state[d] = 0;
         m_data[d] = 16'h0;
         m_chan[d] = 1'b0;
         m_cnt[d] = 0;
      end
   endfunction

   task automatic push(input int d, input int ch, input logic [15:0] v);
      int idx;
      idx = d * 2 + ch;
      @(negedge clk);
      chk($sformatf("push_ready%0d_%0d", d, ch), (ch == 0) ? l_ready[d] : r_ready[d],
          mq[idx].size() < DEPTH);
      case (idx)
         0: begin l_data0 = v; l_valid[0] = 1'b1; end
         1: begin r_data0 = v; r_valid[0] = 1'b1; end
         2: begin l_data1 = v; l_valid[1] = 1'b1; end
         default: begin r_data1 = v; r_valid[1] = 1'b1; end
      endcase
      @(negedge clk);
      l_valid = 2'b00;
      r_valid = 2'b00;
      if (mq[idx].size() < DEPTH) mq[idx].push_back(v);
   endtask

   task automatic do_enable(input int d);
      @(negedge clk);
      enable[d] = 1'b1;
      if (m_state[d] == 0) begin
         m_state[d] = 1;
         m_cnt[d] = 0;
      end
      if (mq[d*2].size() >= plvl(d) && mq[d*2+1].size() >= plvl(d)) begin
         m_data[d] = mq[d*2].pop_front();
         m_hold[d*2] = m_data[d];
         m_chan[d] = 1'b0;
         m_state[d] = 2;
      end
      repeat (4) @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic do_disable(input int d);
      @(negedge clk);
      enable[d] = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("disable_state%0d", d), (d == 0) ? st0 : st1, 0);
      chk($sformatf("disable_data%0d", d), (d == 0) ? data_o0 : data_o1, 0);
      m_state[d] = 0;
      m_data[d] = 16'h0;
      m_chan[d] = 1'b0;
   endtask

   task automatic pulse_done();
      @(posedge clk);
      #($urandom_range(1, 9));
      done_in = 1'b1;
      model_done();
      repeat (4) @(posedge clk);
      #2 done_in = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   initial begin
      // reset values while reset is held
      #12;
      check_all();
      chk("reset_urun0", urun[0], 0);
      chk("reset_urun1", urun[1], 0);
      @(negedge clk);
      rst = 1'b0;

      // prime and order on instance 0
      push(0, 0, 16'h1111);
      push(0, 0, 16'h2222);
      push(0, 1, 16'hAAAA);
      push(0, 1, 16'hBBBB);
      do_enable(0);
      repeat (3) pulse_done();

      // underrun: instance 1 holds, instance 0 (now empty) fills zero
      push(1, 0, 16'h1111);
      push(1, 1, 16'h5555);
      do_enable(1);
      repeat (2) pulse_done();

      // random pushes interleaved with word boundaries at random phases
      for (int it = 0; it < 10; it++) begin
         for (int d = 0; d < 2; d++)
            for (int ch = 0; ch < 2; ch++)
               repeat ($urandom_range(0, 2)) push(d, ch, 16'($urandom));
         pulse_done();
      end

      // disable mid-run; contents retained, re-enable resumes with next left word
      do_disable(0);
      @(negedge clk);
      check_all();
      while (mq[0].size() < 2) push(0, 0, 16'($urandom));
      while (mq[1].size() < 2) push(0, 1, 16'($urandom));
      do_enable(0);
      pulse_done();

      // asynchronous reset between edges, with DONE high during reset
      @(posedge clk);
      #2 done_in = 1'b1;
      #1 rst = 1'b1;
      #1;
      model_reset();
      check_all();
      chk("async_urun0", urun[0], 0);
      chk("async_urun1", urun[1], 0);
      enable = 2'b00;
      repeat (3) @(posedge clk);
      done_in = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      check_all();

      // backpressure: fifth left word is dropped
      push(0, 0, 16'h0001);
      push(0, 0, 16'h0002);
      push(0, 0, 16'h0003);
      push(0, 0, 16'h0004);
      push(0, 0, 16'h0005);
      for (int i = 0; i < 4; i++) push(0, 1, 16'h00A0 + 16'(i));
      do_enable(0);
      repeat (7) pulse_done();

      // three underruns on the drained instance, then restart clears the count
      repeat (3) pulse_done();
      do_disable(0);
      do_enable(0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
